branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
- Consumes the six magnitude/equality flags (gt_u, eq_u, lt_u, gt_s, eq_s, lt_s) that the integer comparator produces for a conditional branch.
- Selects the branch condition by funct3, computes the taken/not-taken target, detects misprediction against the fetch-side prediction, and trains a 2-bit branch history table (BHT).
- Sits between execute and fetch. Results leave through a one-entry registered valid/ready output stage.

Parameters:
- BHT_ENTRIES, 64, number of 2-bit counters; power of two, minimum 2.
- BHT_IDX_W, $clog2(BHT_ENTRIES), index width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  branch request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_funct3  input  3  B-type funct3.
- req_pc  input  32  branch instruction PC.
- req_imm  input  32  sign-extended B-immediate.
- req_pred_taken  input  1  prediction used by fetch.
- gt_u, eq_u, lt_u, gt_s, eq_s, lt_s  input  1 each  comparator flags for rs1 vs rs2.
- resp_valid  output  1  result held in output register.
- resp_ready  input  1  consumer accepts result.
- resp_taken  output  1  branch condition true.
- resp_mispredict  output  1  resp_taken differs from req_pred_taken.
- resp_redirect_pc  output  32  correct next PC.
- resp_illegal  output  1  funct3 was 010 or 011.
- lookup_pc  input  32  fetch-side BHT lookup address.
- lookup_taken  output  1  combinational prediction: MSB of the indexed counter.
- stat_branches  output  32  count of accepted legal branches.
- stat_mispredicts  output  32  count of accepted mispredicted branches.

Behaviour:
- Handshake:
  - Request accept: acc = req_valid & req_ready.
  - req_ready = !resp_valid | resp_ready. Same-cycle drain and refill is allowed.
  - Response hold: while resp_valid & !resp_ready, all resp_* outputs hold stable.
  - Response clear: resp_valid clears when resp_ready is high and no new acc occurs.
- Latency: one cycle. Signals accepted at edge N are visible on resp_* after edge N.
- Condition select (taken):
  - 000 BEQ = eq_s
  - 001 BNE = !eq_s
  - 100 BLT = lt_s
  - 101 BGE = !lt_s
  - 110 BLTU = lt_u
  - 111 BGEU = !lt_u
  - gt_* and eq_u are not used for selection but are ported for interface completeness.
- Illegal funct3 (010, 011):
  - resp_illegal=1, resp_taken=0, resp_mispredict=0.
  - resp_redirect_pc = req_pc+4.
  - No BHT update; counters unchanged.
- Arithmetic:
  - Target = req_pc + req_imm, 32-bit, wrapping modulo 2^32. Fallthrough = req_pc + 4, also wrapping.
  - resp_redirect_pc = taken ? target : fallthrough.
  - No alignment check on the target.
- BHT index: pc[BHT_IDX_W+1:2] for both lookup and update.
- BHT update on acc of a legal branch:
  - Taken: increment, saturating at 11.
  - Not taken: decrement, saturating at 00.
- BHT read/write collision: a lookup to the index being updated in the same cycle returns the pre-update value. No bypass.
- Statistics: on acc of a legal branch, stat_branches += 1; if mispredicted, stat_mispredicts += 1. Both wrap at 2^32.
- Reset (rst=1 at an edge), which takes priority over any acc in that cycle:
  - resp_valid=0.
  - resp_taken, resp_mispredict, resp_illegal = 0; resp_redirect_pc = 0.
  - All BHT counters = 01 (weakly not taken), so lookup_taken = 0.
  - stat_* = 0.
  - A pending response is discarded.

Decomposition:
- Shared package, branch_pkg:
  - funct3 localparams F3_BEQ..F3_BGEU.
  - typedef cmp_flags_t: packed struct of the six flags.
  - typedef bht_ctr_t: logic[1:0].
  - BHT_RESET_VAL = 2'b01.
- One sub-module, bht_2bit: counter array, combinational read port, saturating synchronous update port, synchronous reset.

Test Plan:
- BEQ taken:
  - Stimulus: pc=0x100, imm=0x20, eq_s=1, pred=0, resp_ready=1.
  - Required: next cycle taken=1, mispredict=1, redirect=0x120, stat_mispredicts=1.
- BGEU not taken:
  - Stimulus: lt_u=1, pc=0x200, pred=0.
  - Required: taken=0, mispredict=0, redirect=0x204.
- Backpressure:
  - Stimulus: resp_ready=0 for 3 cycles while req_valid=1.
  - Required: req_ready=0 after the first accept, outputs stable, second request accepted the cycle resp_ready=1.
- BHT saturation:
  - Stimulus: 3 taken branches at pc=0x40.
  - Required: lookup_pc=0x40 gives lookup_taken 0 after reset, 1 after the first update, and the counter stays at 11.
  - Then 3 not-taken branches at the same pc: counter goes to 00.
- Illegal funct3 and wrap:
  - Illegal: funct3=010 gives illegal=1, redirect=pc+4, stat_branches unchanged.
  - Wrap: pc=0xFFFFFFF0, imm=0x20, eq_s=1 gives redirect=0x00000010.
- Reset mid-operation:
  - Stimulus: rst while resp_valid=1 with an acc in the same cycle.
  - Required: resp_valid=0 next cycle, stats=0, lookup_taken=0 for all indices.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve unit: funct3 encodings,
// comparator flag bundle and BHT counter type.
package branch_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic gt_u;
    logic eq_u;
    logic lt_u;
    logic gt_s;
    logic eq_s;
    logic lt_s;
  } cmp_flags_t;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET_VAL = 2'b01;

  function automatic logic is_legal_f3(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  // Reserved encodings fall to the default and report not-taken.
  function automatic logic branch_cond(input logic [2:0] f3, input cmp_flags_t f);
    logic taken;
    taken = 1'b0;
    case (f3)
      F3_BEQ:  taken = f.eq_s;
      F3_BNE:  taken = !f.eq_s;
      F3_BLT:  taken = f.lt_s;
      F3_BGE:  taken = !f.lt_s;
      F3_BLTU: taken = f.lt_u;
      F3_BGEU: taken = !f.lt_u;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Table of 2-bit saturating branch-history counters with a combinational read
// port and a synchronous update port.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_ctr_t         rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken
);

  bht_ctr_t ctr_q [ENTRIES];

  // Read sees the stored value, so a same-cycle update is not bypassed.
  assign rd_ctr = ctr_q[rd_idx];

  always_ff @(posedge clk) begin
    // NOTE: every counter must come out of reset weakly not-taken, so the table
    // is a resettable flop array rather than an un-reset RAM.
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= BHT_RESET_VAL;
    end else if (wr_en) begin
      if (wr_taken && ctr_q[wr_idx] != 2'b11)
        ctr_q[wr_idx] <= ctr_q[wr_idx] + 2'd1;
      else if (!wr_taken && ctr_q[wr_idx] != 2'b00)
        ctr_q[wr_idx] <= ctr_q[wr_idx] - 2'd1;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches from comparator flags, computes the redirect
// PC, flags mispredictions and trains the BHT; one registered output stage.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int BHT_ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_imm,
  input  logic        req_pred_taken,
  input  logic        gt_u,
  input  logic        eq_u,
  input  logic        lt_u,
  input  logic        gt_s,
  input  logic        eq_s,
  input  logic        lt_s,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_taken,
  output logic        resp_mispredict,
  output logic [31:0] resp_redirect_pc,
  output logic        resp_illegal,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);

  cmp_flags_t flags;
  logic       acc;
  logic       legal;
  logic       taken;
  logic       mispredict;
  logic [31:0] redirect_pc;
  bht_ctr_t   lookup_ctr;

  assign flags      = {gt_u, eq_u, lt_u, gt_s, eq_s, lt_s};
  assign req_ready  = !resp_valid || resp_ready;
  assign acc        = req_valid && req_ready;
  assign legal      = is_legal_f3(req_funct3);
  assign taken      = legal && branch_cond(req_funct3, flags);
  assign mispredict = legal && (taken != req_pred_taken);
  // Both sums wrap modulo 2^32; no alignment check on the target.
  assign redirect_pc = taken ? (req_pc + req_imm) : (req_pc + 32'd4);

  // Flags and address bits that the selection logic does not need.
  logic unused_bits;
  assign unused_bits = ^{flags.gt_u, flags.eq_u, flags.gt_s,
                         lookup_pc[31:BHT_IDX_W+2], lookup_pc[1:0]};

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (BHT_IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (lookup_pc[BHT_IDX_W+1:2]),
    .rd_ctr   (lookup_ctr),
    .wr_en    (acc && legal),
    .wr_idx   (req_pc[BHT_IDX_W+1:2]),
    .wr_taken (taken)
  );

  assign lookup_taken = lookup_ctr[1];

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      resp_valid       <= 1'b0;
      resp_taken       <= 1'b0;
      resp_mispredict  <= 1'b0;
      resp_redirect_pc <= 32'd0;
      resp_illegal     <= 1'b0;
    end else if (acc) begin
      resp_valid       <= 1'b1;
      resp_taken       <= taken;
      resp_mispredict  <= mispredict;
      resp_redirect_pc <= redirect_pc;
      resp_illegal     <= !legal;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else if (acc && legal) begin
      stat_branches <= stat_branches + 32'd1;
      if (mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end

endmodule
